aes_rkey_sched_ctrl: RTL and testbench
======================================

// Module: aes_rkey_sched_ctrl
// PURPOSE
//  Sequences the single-round AES-128 key-expansion unit to precompute all round keys into a local file.
//  - Load: on key load, stores RK0, then issues NROUNDS start/ready transactions, feeding each result back.
//  - Serve: arbitrates round-key reads from two cipher cores (A = encrypt, B = decrypt) round-robin.
//  - Placement: between AXI-lite key register and the enc/dec round pipelines.
// PARAMETERS
//  NROUNDS     10     expansion steps; file holds NROUNDS+1 keys (RK0..RK10)
//  KX_TIMEOUT  64     max cycles in WAIT before the transaction is declared failed
// PORTS
//  clk          in   1    clock
//  rst_n        in   1    reset
//  key_load_i   in   1    load pulse; key_i sampled on it
//  key_i        in   128  cipher key
//  busy_o       out  1    expansion in progress
//  keys_valid_o out  1    all NROUNDS+1 round keys valid
//  kx_err_o     out  1    sticky: expansion timed out; cleared by next accepted load
//  kx_start_o   out  1    one-cycle start to expansion unit
//  kx_rd_num_o  out  4    round index for expansion unit (rcon select), 0..NROUNDS-1
//  kx_key_o     out  128  previous round key to expansion unit
//  kx_ready_i   in   1    expansion result valid (one-cycle pulse)
//  kx_key_i     in   128  expanded round key
//  req_a_i      in   1    port A read request
//  idx_a_i      in   4    port A round index
//  req_b_i      in   1    port B read request
//  idx_b_i      in   4    port B round index
//  gnt_a_o      out  1    port A granted (comb.)
//  gnt_b_o      out  1    port B granted (comb.)
//  rvalid_a_o   out  1    rdata_o belongs to A (1 cycle after gnt_a_o)
//  rvalid_b_o   out  1    rdata_o belongs to B (1 cycle after gnt_b_o)
//  rdata_o      out  128  registered round key
//  rerr_o       out  1    with rvalid: index > NROUNDS, rdata_o = 0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, RR pointer = A, key file not cleared (contents don't-care).
//  FSM states:
//   - IDLE/DONE --key_load_i--> ISSUE: rk[0] <= key_i, idx <= 0, keys_valid_o <= 0, busy_o <= 1, kx_err_o <= 0.
//   - ISSUE: kx_start_o = 1 for exactly this cycle, kx_rd_num_o = idx, kx_key_o = rk[idx]; -> WAIT next cycle.
//   - WAIT: on kx_ready_i, rk[idx+1] <= kx_key_i.
//     - If idx == NROUNDS-1 -> DONE (keys_valid_o <= 1, busy_o <= 0).
//     - Else idx++ -> ISSUE.
//   - WAIT timeout: KX_TIMEOUT cycles without ready -> IDLE, kx_err_o <= 1, busy_o <= 0, keys_valid_o stays 0.
//  kx_rd_num_o/kx_key_o held stable from ISSUE through WAIT.
//  kx_ready_i outside WAIT is ignored. Ready in the same cycle as the timeout expiry wins (key stored).
//  key_load_i while busy_o = 1 is ignored (no restart).
//  key_load_i in DONE: keys_valid_o drops the next cycle; no new grants from that cycle on.
//  Min load latency: 1 + 2*NROUNDS cycles (1-cycle kx unit) from load to keys_valid_o.
//  Arbitration (only while keys_valid_o = 1; otherwise gnt = 0 and requests stall):
//   - Single requester is granted.
//   - Both requesting: grant the port at the RR pointer; pointer moves to the other port only after a contested grant.
//   - Max one grant per cycle. A held request is regranted every cycle (back-to-back reads allowed).
//   - Next cycle: rdata_o = rk[idx] and the matching rvalid_*_o pulses.
//   - Index > NROUNDS: rdata_o = 0, rerr_o = 1 with rvalid.
//  Reset asserted mid-expansion: immediate return to IDLE, keys_valid_o = 0, pending read discarded.
// TESTING
//  1 Load 2b7e1516_28aed2a6_abf71588_09cf4f3c with a real kx unit -> 10 kx_start pulses, rd_num 0..9, keys_valid_o=1; read idx 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
//  2 Kx model with 3-cycle ready latency -> keys_valid_o exactly 1+10*4 cycles after load; RK1 = a0fafe17_88542cb1_23a33939_2a6c7605.
//  3 req_a and req_b held 6 cycles with keys valid -> grants alternate A,B,A,B,A,B; each rvalid one cycle after its grant, correct data.
//  4 Kx model never asserts ready -> after 64 WAIT cycles: kx_err_o=1, busy_o=0, keys_valid_o=0; next load clears kx_err_o.
//  5 Second key_load_i at round 4 -> ignored, 10 rounds complete; load in DONE -> keys_valid_o falls next cycle, reqs stall until new keys valid.
//  6 rst_n pulsed during round 6 with req_a high -> all outputs 0; idx_a=11 after a reload -> rerr_o=1, rdata_o=0.

Source files
------------

// File: rtl/aes_rkey_sched_ctrl.sv
// Round-key schedule controller: drives a single-round AES-128 key-expansion unit to fill a
// local round-key file, then serves round-key reads to two cipher cores with round-robin arbitration.
module aes_rkey_sched_ctrl #(
  parameter int NROUNDS    = 10,
  parameter int KX_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         keys_valid_o,
  output logic         kx_err_o,
  output logic         kx_start_o,
  output logic [3:0]   kx_rd_num_o,
  output logic [127:0] kx_key_o,
  input  logic         kx_ready_i,
  input  logic [127:0] kx_key_i,
  input  logic         req_a_i,
  input  logic [3:0]   idx_a_i,
  input  logic         req_b_i,
  input  logic [3:0]   idx_b_i,
  output logic         gnt_a_o,
  output logic         gnt_b_o,
  output logic         rvalid_a_o,
  output logic         rvalid_b_o,
  output logic [127:0] rdata_o,
  output logic         rerr_o,
  output logic [1:0]   dbg_state
);

  // Handshake: kx_start_o is a one-cycle request carrying kx_rd_num_o/kx_key_o, which stay stable
  // until the single-cycle kx_ready_i pulse (or the timeout); a read grant is answered by exactly
  // one rvalid pulse on the following cycle.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam int            TW      = $clog2(KX_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(KX_TIMEOUT - 1);
  localparam logic [3:0]    LAST_RD = 4'(NROUNDS - 1);
  localparam logic [3:0]    MAX_IDX = 4'(NROUNDS);

  state_t        state, state_nxt;
  logic [3:0]    rd_idx;
  logic [TW-1:0] timer;
  logic [127:0]  kx_key_q;
  logic [127:0]  rk [16];
  logic          ptr_b;
  logic          load_ok, kx_hit;
  logic [3:0]    sel_idx;
  logic          sel_bad;

  assign load_ok     = key_load_i && (state == S_IDLE || state == S_DONE);
  assign kx_hit      = (state == S_WAIT) && kx_ready_i;
  assign kx_start_o  = (state == S_ISSUE);
  assign kx_rd_num_o = rd_idx;
  assign kx_key_o    = kx_key_q;
  assign dbg_state   = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (key_load_i) state_nxt = S_ISSUE;
      S_ISSUE:        state_nxt = S_WAIT;
      S_WAIT: begin
        if (kx_ready_i)            state_nxt = (rd_idx == LAST_RD) ? S_DONE : S_ISSUE;
        else if (timer == T_LAST)  state_nxt = S_IDLE;
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o       <= 1'b0;
      keys_valid_o <= 1'b0;
      kx_err_o     <= 1'b0;
      rd_idx       <= '0;
      timer        <= '0;
      kx_key_q     <= '0;
    end else begin
      if (load_ok) begin
        busy_o       <= 1'b1;
        keys_valid_o <= 1'b0;
        kx_err_o     <= 1'b0;
        rd_idx       <= '0;
        kx_key_q     <= key_i;
      end
      if (state == S_ISSUE) timer <= '0;
      // A ready arriving on the last timeout cycle still counts as a completed round.
      if (state == S_WAIT) begin
        if (kx_ready_i) begin
          kx_key_q <= kx_key_i;
          if (rd_idx == LAST_RD) begin
            busy_o       <= 1'b0;
            keys_valid_o <= 1'b1;
          end else begin
            rd_idx <= rd_idx + 4'd1;
          end
        end else if (timer == T_LAST) begin
          busy_o   <= 1'b0;
          kx_err_o <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  // Key file contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_ok)     rk[0]             <= key_i;
    else if (kx_hit) rk[rd_idx + 4'd1] <= kx_key_i;
  end

  assign gnt_a_o = keys_valid_o && req_a_i && (!req_b_i || !ptr_b);
  assign gnt_b_o = keys_valid_o && req_b_i && (!req_a_i ||  ptr_b);
  assign sel_idx = gnt_a_o ? idx_a_i : idx_b_i;
  assign sel_bad = (sel_idx > MAX_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_b      <= 1'b0;
      rvalid_a_o <= 1'b0;
      rvalid_b_o <= 1'b0;
      rerr_o     <= 1'b0;
      rdata_o    <= '0;
    end else begin
      rvalid_a_o <= gnt_a_o;
      rvalid_b_o <= gnt_b_o;
      rerr_o     <= (gnt_a_o || gnt_b_o) && sel_bad;
      if (gnt_a_o || gnt_b_o) rdata_o <= sel_bad ? '0 : rk[sel_idx];
      if (keys_valid_o && req_a_i && req_b_i) ptr_b <= !ptr_b;
    end
  end

endmodule

// File: tb/tb_aes_rkey_sched_ctrl.sv
// Bench for aes_rkey_sched_ctrl: behavioural AES key-expansion unit, arbitration model and a
// read scoreboard fed at grant time and drained by an independent rvalid monitor.
module tb_aes_rkey_sched_ctrl;
  localparam int NR  = 10;
  localparam int KXT = 64;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_load_i;
  logic [127:0] key_i;
  logic         busy_o, keys_valid_o, kx_err_o, kx_start_o;
  logic [3:0]   kx_rd_num_o;
  logic [127:0] kx_key_o;
  logic         kx_ready_i;
  logic [127:0] kx_key_i;
  logic         req_a_i, req_b_i;
  logic [3:0]   idx_a_i, idx_b_i;
  logic         gnt_a_o, gnt_b_o, rvalid_a_o, rvalid_b_o, rerr_o;
  logic [127:0] rdata_o;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  aes_rkey_sched_ctrl #(.NROUNDS(NR), .KX_TIMEOUT(KXT)) dut (
    .clk(clk), .rst_n(rst_n), .key_load_i(key_load_i), .key_i(key_i),
    .busy_o(busy_o), .keys_valid_o(keys_valid_o), .kx_err_o(kx_err_o),
    .kx_start_o(kx_start_o), .kx_rd_num_o(kx_rd_num_o), .kx_key_o(kx_key_o),
    .kx_ready_i(kx_ready_i), .kx_key_i(kx_key_i),
    .req_a_i(req_a_i), .idx_a_i(idx_a_i), .req_b_i(req_b_i), .idx_b_i(idx_b_i),
    .gnt_a_o(gnt_a_o), .gnt_b_o(gnt_b_o), .rvalid_a_o(rvalid_a_o), .rvalid_b_o(rvalid_b_o),
    .rdata_o(rdata_o), .rerr_o(rerr_o), .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 128'(act), 128'(exp));
  endtask

  // ---------------- AES-128 reference (FIPS-197 key expansion) ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      if (v != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_t[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] kx_step(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < r; i++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    {w0, w1, w2, w3} = k;
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] ref_rk [16];

  task automatic set_ref(input logic [127:0] k);
    for (int i = 0; i < 16; i++) ref_rk[i] = '0;
    ref_rk[0] = k;
    for (int i = 0; i < NR; i++) ref_rk[i+1] = kx_step(ref_rk[i], i);
  endtask

  // ---------------- behavioural expansion unit ----------------
  int           kx_lat    = 1;
  bit           kx_dead   = 1'b0;
  int           kx_cnt    = 0;
  int           kx_nstart = 0;
  logic [3:0]   kx_rd_save;
  logic [127:0] kx_key_save;

  initial begin
    kx_ready_i = 1'b0;
    kx_key_i   = '0;
    forever begin
      @(negedge clk);
      kx_ready_i = 1'b0;
      if (!rst_n) begin
        kx_cnt = 0;
      end else begin
        if (kx_cnt > 0) begin
          kx_cnt--;
          if (kx_cnt == 0) begin
            kx_ready_i = 1'b1;
            kx_key_i   = kx_step(kx_key_save, int'(kx_rd_save));
            chk("kx_hold_rd", 128'(kx_rd_num_o), 128'(kx_rd_save));
            chk("kx_hold_key", kx_key_o, kx_key_save);
          end
        end
        if (kx_start_o) begin
          chk("kx_rd_num", 128'(kx_rd_num_o), 128'(kx_nstart));
          if (kx_nstart < NR) chk("kx_key_out", kx_key_o, ref_rk[kx_nstart]);
          kx_nstart++;
          kx_rd_save  = kx_rd_num_o;
          kx_key_save = kx_key_o;
          if (!kx_dead) kx_cnt = kx_lat;
        end
      end
    end
  end

  // ---------------- scoreboard and monitor ----------------
  logic [129:0] exp_q[$];
  logic [129:0] mon_e;
  logic [127:0] last_rd = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("rd_valid", 128'({rvalid_b_o, rvalid_a_o}), 128'(mon_e[129] ? 2'b10 : 2'b01));
          chk1("rd_err", rerr_o, mon_e[128]);
          chk("rd_data", rdata_o, mon_e[127:0]);
          last_rd = rdata_o;
        end else begin
          chk("rd_spurious", 128'({rvalid_b_o, rvalid_a_o, rerr_o}), 128'(0));
        end
      end
    end
  end

  // ---------------- driver ----------------
  logic ptr_m   = 1'b0;
  bit   keys_ok = 1'b0;
  bit   last_gb = 1'b0;

  task automatic cycle_req(input bit a, input logic [3:0] ia, input bit b, input logic [3:0] ib,
                           input bit ld, input logic [127:0] k);
    bit ga, gb, bad;
    logic [3:0] idx;
    @(negedge clk);
    req_a_i = a; idx_a_i = ia; req_b_i = b; idx_b_i = ib;
    key_load_i = ld; key_i = k;
    #1;
    ga = 1'b0; gb = 1'b0;
    if (keys_ok && a && b) begin
      if (ptr_m) gb = 1'b1; else ga = 1'b1;
      ptr_m = ~ptr_m;
    end else if (keys_ok && a) ga = 1'b1;
    else if (keys_ok && b) gb = 1'b1;
    chk("gnt", 128'({gnt_b_o, gnt_a_o}), 128'({gb, ga}));
    last_gb = gb;
    if (ga || gb) begin
      idx = ga ? ia : ib;
      bad = (int'(idx) > NR);
      exp_q.push_back({gb, bad, bad ? 128'h0 : ref_rk[idx]});
    end
  endtask

  task automatic idle();
    cycle_req(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, '0);
  endtask

  task automatic check_zero_outs();
    chk1("z_busy", busy_o, 1'b0);
    chk1("z_keys_valid", keys_valid_o, 1'b0);
    chk1("z_kx_err", kx_err_o, 1'b0);
    chk1("z_kx_start", kx_start_o, 1'b0);
    chk("z_kx_rd_num", 128'(kx_rd_num_o), 128'(0));
    chk("z_kx_key", kx_key_o, 128'(0));
    chk("z_gnt", 128'({gnt_b_o, gnt_a_o}), 128'(0));
    chk("z_rvalid", 128'({rvalid_b_o, rvalid_a_o}), 128'(0));
    chk1("z_rerr", rerr_o, 1'b0);
    chk("z_rdata", rdata_o, 128'(0));
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outs();
    repeat (n) @(negedge clk);
    exp_q.delete();
    ptr_m   = 1'b0;
    keys_ok = 1'b0;
    rst_n   = 1'b1;
  endtask

  // Load cycle is k=0; with an L-cycle unit each round costs L+1 cycles, so keys are valid at
  // k = 1+(L+1)*NR. A dead unit gives ISSUE at k=1, KXT wait cycles, error visible at k=2+KXT.
  task automatic run_load(input logic [127:0] k, input int lat, input bit dead,
                          input bit hold_a, input logic [3:0] ia, input int ign_k);
    int last_k;
    set_ref(k);
    kx_lat = lat; kx_dead = dead; kx_nstart = 0;
    cycle_req(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, k);
    keys_ok = 1'b0;
    last_k = dead ? (2 + KXT) : (1 + (lat + 1) * NR);
    for (int kk = 1; kk <= last_k; kk++) begin
      keys_ok = !dead && (kk == last_k);
      cycle_req(hold_a, ia, 1'b0, 4'd0, kk == ign_k, ~k);
      chk1("keys_valid", keys_valid_o, keys_ok);
      if (kk == 1) begin
        chk1("busy_after_load", busy_o, 1'b1);
        chk1("err_cleared_by_load", kx_err_o, 1'b0);
      end
      if (dead) chk1("kx_err_timing", kx_err_o, kk == last_k);
      if (kk == last_k) chk1("busy_end", busy_o, 1'b0);
    end
    if (!dead) chk("kx_start_count", 128'(kx_nstart), 128'(NR));
    idle();
  endtask

  logic [5:0]   seq;
  logic [127:0] rkey;

  initial begin
    rst_n = 1'b0;
    key_load_i = 1'b0; key_i = '0;
    req_a_i = 1'b0; req_b_i = 1'b0; idx_a_i = '0; idx_b_i = '0;
    build_sbox();
    set_ref(FIPS_KEY);
    apply_reset(3);

    // known-answer load with a 1-cycle unit
    run_load(FIPS_KEY, 1, 1'b0, 1'b0, 4'd0, -1);
    cycle_req(1'b1, 4'd10, 1'b0, 4'd0, 1'b0, '0);
    idle();
    chk("fips_rk10", last_rd, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    for (int i = 0; i <= NR; i++)
      cycle_req(i % 2 == 0, 4'(i), i % 2 == 1, 4'(i), 1'b0, '0);
    idle();

    // 3-cycle unit latency
    run_load(FIPS_KEY, 3, 1'b0, 1'b0, 4'd0, -1);
    cycle_req(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, '0);
    idle();
    chk("fips_rk1", last_rd, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);

    // contested requests alternate starting from A
    for (int i = 0; i < 6; i++) begin
      cycle_req(1'b1, 4'($urandom_range(0, NR)), 1'b1, 4'($urandom_range(0, NR)), 1'b0, '0);
      seq[i] = last_gb;
    end
    idle();
    chk("rr_sequence", 128'(seq), 128'(6'b101010));

    // unit never answers, then a good load clears the error
    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_load(rkey, 1, 1'b1, 1'b0, 4'd0, -1);
    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_load(rkey, 2, 1'b0, 1'b0, 4'd0, -1);

    // load during round 4 is ignored; load in DONE stalls a held request
    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_load(rkey, 1, 1'b0, 1'b0, 4'd0, 9);
    for (int i = 0; i <= NR; i++) cycle_req(1'b0, 4'd0, 1'b1, 4'(i), 1'b0, '0);
    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_load(rkey, 2, 1'b0, 1'b1, 4'd5, -1);

    // randomized traffic over several keys and unit latencies
    repeat (4) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_load(rkey, $urandom_range(1, 4), 1'b0, 1'b0, 4'd0, -1);
      repeat (30)
        cycle_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, '0);
      idle();
    end

    // reset during round 6 with a pending request, then out-of-range read
    set_ref(FIPS_KEY);
    kx_lat = 1; kx_dead = 1'b0; kx_nstart = 0;
    cycle_req(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, FIPS_KEY);
    keys_ok = 1'b0;
    for (int kk = 1; kk <= 13; kk++) cycle_req(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, '0);
    chk("round6_rd_num", 128'(kx_rd_num_o), 128'(6));
    apply_reset(2);
    rkey = {$urandom, $urandom, $urandom, $urandom};
    run_load(rkey, 1, 1'b0, 1'b0, 4'd0, -1);
    cycle_req(1'b1, 4'd11, 1'b0, 4'd0, 1'b0, '0);
    idle();
    chk("idx11_rdata", last_rd, 128'(0));

    repeat (3) idle();
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
